// File: rtl/umi_regbank.sv
// Flop-based register bank behind umi_regif.
// One request per transaction, optional wait states, UMI error codes.
module umi_regbank #(
  parameter int          RW   = 32,
  parameter int          AW   = 64,
  parameter int          REGS = 16,
  parameter int          WAIT = 0,
  parameter logic [RW-1:0] ID = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          reg_write,
  input  logic          reg_read,
  input  logic [AW-1:0] reg_addr,
  input  logic [RW-1:0] reg_wrdata,
  input  logic [1:0]    reg_prot,
  output logic [RW-1:0] reg_rddata,
  output logic          reg_ready,
  output logic [1:0]    reg_err,
  output logic          busy
);

  localparam int IW = $clog2(REGS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [7:0] WLOAD =
    (WAIT > 0) ? 8'(WAIT - 1) : 8'd0;
  localparam logic [1:0] S_NEXT =
    (WAIT > 0) ? S_WAIT : S_RESP;

  logic [1:0]    state;
  logic [7:0]    cnt;
  logic [RW-1:0] regs [1:REGS-1];

  logic [IW-1:0] idx;
  logic          req;
  logic          dec_err;
  logic          dev_err;
  logic [1:0]    err;
  logic          we;
  logic [RW-1:0] rd_val;
  logic          unused;

  assign idx = reg_addr[2 +: IW];
  assign req = reg_write | reg_read;
  assign unused = reg_prot[1];

  assign dec_err = |reg_addr[AW-1:2+IW];

  // The upper half of the bank is write-protected for unprivileged masters.
  assign dev_err = (|reg_addr[1:0])
    | (reg_write & (idx == '0))
    | (reg_write & idx[IW-1] & ~reg_prot[0]);

  always_comb begin
    err = 2'b00;
    if (dec_err)
      err = 2'b11;
    else if (dev_err)
      err = 2'b10;
  end

  assign we = reg_write & (err == 2'b00);

  always_comb begin
    rd_val = '0;
    if (idx == '0)
      rd_val = ID;
    for (int i = 1; i < REGS; i++)
      if (idx == IW'(i))
        rd_val = regs[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      reg_rddata <= '0;
      reg_err    <= 2'b00;
      for (int i = 1; i < REGS; i++)
        regs[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            reg_err <= err;
            reg_rddata <=
              (~reg_write && err == 2'b00)
              ? rd_val : '0;
            for (int i = 1; i < REGS; i++)
              if (we && idx == IW'(i))
                regs[i] <= reg_wrdata;
            cnt   <= WLOAD;
            state <= S_NEXT;
          end
        end
        S_WAIT: begin
          if (cnt == 8'd0)
            state <= S_RESP;
          else
            cnt <= cnt - 8'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign reg_ready = (state == S_RESP);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_umi_regbank.sv
// Directed bench for umi_regbank: WAIT=0 and WAIT=3 instances.
// Expected values are hand-computed constants.
module tb_umi_regbank;

  localparam logic [31:0] IDV = 32'hC0DE_0001;

  logic        clk;
  logic        rst [2];
  logic        wr  [2];
  logic        rd  [2];
  logic [63:0] ad  [2];
  logic [31:0] wd  [2];
  logic [1:0]  pr  [2];
  logic [31:0] rdd [2];
  logic        rdy [2];
  logic [1:0]  er  [2];
  logic        bsy [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] d;
  logic [1:0]  e;
  int          lat;

  umi_regbank #(.WAIT(0), .ID(IDV)) u0 (
    .clk(clk), .reset(rst[0]),
    .reg_write(wr[0]), .reg_read(rd[0]),
    .reg_addr(ad[0]), .reg_wrdata(wd[0]),
    .reg_prot(pr[0]), .reg_rddata(rdd[0]),
    .reg_ready(rdy[0]), .reg_err(er[0]),
    .busy(bsy[0])
  );

  umi_regbank #(.WAIT(3), .ID(IDV)) u3 (
    .clk(clk), .reset(rst[1]),
    .reg_write(wr[1]), .reg_read(rd[1]),
    .reg_addr(ad[1]), .reg_wrdata(wd[1]),
    .reg_prot(pr[1]), .reg_rddata(rdd[1]),
    .reg_ready(rdy[1]), .reg_err(er[1]),
    .busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tx(input int s,
                    input logic w, input logic r,
                    input logic [63:0] a,
                    input logic [31:0] dat,
                    input logic [1:0] p,
                    output logic [31:0] rdo,
                    output logic [1:0] eo,
                    output int lo);
    @(negedge clk);
    wr[s] = w; rd[s] = r; ad[s] = a;
    wd[s] = dat; pr[s] = p;
    lo = -1; rdo = 'x; eo = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rdy[s]) begin
        lo = k; rdo = rdd[s]; eo = er[s];
        break;
      end
    end
    @(posedge clk);
    #1;
    wr[s] = 1'b0; rd[s] = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; wr[s] = 1'b0; rd[s] = 1'b0;
      ad[s] = '0; wd[s] = '0; pr[s] = 2'b00;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, rdy[0]}, 64'd0);
    chk("rst_busy", {63'd0, bsy[0]}, 64'd0);
    chk("rst_err", {62'd0, er[0]}, 64'd0);
    chk("rst_rddata", {32'd0, rdd[0]}, 64'd0);

    tx(0, 1, 0, 64'h8, 32'hDEADBEEF, 2'b00, d, e, lat);
    chk("wr8_lat", lat, 1);
    chk("wr8_err", e, 2'b00);
    tx(0, 0, 1, 64'h8, 0, 2'b00, d, e, lat);
    chk("rd8_lat", lat, 1);
    chk("rd8_data", d, 32'hDEADBEEF);
    chk("rd8_err", e, 2'b00);

    tx(0, 0, 1, 64'h0, 0, 2'b00, d, e, lat);
    chk("rd0_id", d, IDV);
    chk("rd0_err", e, 2'b00);
    tx(0, 1, 0, 64'h0, 32'h1234, 2'b01, d, e, lat);
    chk("wr0_err", e, 2'b10);
    tx(0, 0, 1, 64'h0, 0, 2'b00, d, e, lat);
    chk("rd0_again", d, IDV);

    tx(0, 1, 0, 64'h6, 32'h9999, 2'b01, d, e, lat);
    chk("mis_err", e, 2'b10);
    tx(0, 0, 1, 64'h4, 0, 2'b00, d, e, lat);
    chk("mis_r1", d, 32'h0);
    tx(0, 0, 1, 64'h8, 0, 2'b00, d, e, lat);
    chk("mis_r2", d, 32'hDEADBEEF);

    tx(0, 0, 1, 64'h1_0000_0040, 0, 2'b01,
       d, e, lat);
    chk("dec_err", e, 2'b11);
    chk("dec_data", d, 32'h0);
    tx(0, 1, 0, 64'h1_0000_0040, 32'h1, 2'b01,
       d, e, lat);
    chk("dec_werr", e, 2'b11);

    tx(0, 1, 0, 64'h20, 32'h55, 2'b00, d, e, lat);
    chk("unpriv_err", e, 2'b10);
    tx(0, 0, 1, 64'h20, 0, 2'b00, d, e, lat);
    chk("unpriv_rd", d, 32'h0);
    chk("unpriv_rerr", e, 2'b00);
    tx(0, 1, 0, 64'h20, 32'h55, 2'b01, d, e, lat);
    chk("priv_err", e, 2'b00);
    tx(0, 0, 1, 64'h20, 0, 2'b00, d, e, lat);
    chk("priv_rd", d, 32'h55);

    tx(0, 0, 1, 64'h8, 0, 2'b00, d, e, lat);
    tx(0, 1, 1, 64'h4, 32'hA5, 2'b00, d, e, lat);
    chk("both_data", d, 32'h0);
    chk("both_err", e, 2'b00);
    tx(0, 0, 1, 64'h4, 0, 2'b00, d, e, lat);
    chk("both_rd", d, 32'hA5);

    tx(1, 1, 0, 64'h8, 32'h77, 2'b00, d, e, lat);
    chk("w3_lat", lat, 4);
    tx(1, 0, 1, 64'h8, 0, 2'b00, d, e, lat);
    chk("w3_rd", d, 32'h77);

    @(negedge clk);
    rd[1] = 1'b1; ad[1] = 64'h8;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("w3_busy%0d", k),
          {63'd0, bsy[1]}, 64'd1);
      chk($sformatf("w3_ready%0d", k),
          {63'd0, rdy[1]}, (k == 4) ? 64'd1 : 64'd0);
    end
    @(posedge clk);
    #1;
    rd[1] = 1'b0;

    @(negedge clk);
    rd[1] = 1'b1; ad[1] = 64'h8;
    @(negedge clk);
    @(negedge clk);
    rst[1] = 1'b1; rd[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("rst3_busy", {63'd0, bsy[1]}, 64'd0);
    chk("rst3_ready", {63'd0, rdy[1]}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst3_nopulse%0d", k),
          {63'd0, rdy[1]}, 64'd0);
    end
    tx(1, 0, 1, 64'h8, 0, 2'b00, d, e, lat);
    chk("rst3_rd8", d, 32'h0);
    tx(1, 0, 1, 64'h0, 0, 2'b00, d, e, lat);
    chk("rst3_id", d, IDV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
